cv32e40p_apu_shared_arbiter: RTL

// - Shares one APU/FPU interconnect port between N_REQ requesting EX stages (cluster shared FPU).
// - Each requester's EX stage treats its port exactly like a private APU (req/gnt, rvalid/result).
// - Round-robin arbitration on the request channel; responses routed back in order via an ID FIFO.

---
 rtl/cv32e40p_apu_shared_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_apu_shared_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_shared_arbiter
//
// Lets N_REQ EX stages share one APU/FPU interconnect port. Each requester
// sees a private-APU style req/gnt + rvalid/result interface. Requests are
// arbitrated round-robin. A request that was offered but not granted is
// locked in until its handshake, so it is never reordered or dropped.
// Granted requester IDs are queued in a small FIFO so that in-order responses
// can be steered back to the requester that issued them.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_i           per-requester request
//   operands_i      per-requester operands (NARGS x 32 bits each)
//   op_i            per-requester opcode
//   gnt_o           per-requester grant (onehot or zero, combinational)
//   rvalid_o        per-requester response valid (onehot or zero, combinational)
//   result_o        response data, broadcast to all requesters
//   flags_o         response flags, broadcast to all requesters
//   apu_req_o       request to the shared APU
//   apu_gnt_i       grant from the shared APU
//   apu_operands_o  operands of the selected requester
//   apu_op_o        opcode of the selected requester
//   apu_rvalid_i    response valid from the shared APU
//   apu_result_i    response data from the shared APU
//   apu_flags_i     response flags from the shared APU
//   outstanding_o   number of granted transactions still awaiting a response
//   spurious_o      sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module cv32e40p_apu_shared_arbiter #(
  parameter int N_REQ         = 2,
  parameter int DEPTH         = 4,
  parameter int APU_NARGS_CPU = 3,
  parameter int APU_WOP_CPU   = 6,
  parameter int APU_NUSFLAGS  = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ*APU_NARGS_CPU*32-1:0]   operands_i,
  input  logic [N_REQ*APU_WOP_CPU-1:0]        op_i,
  output logic [N_REQ-1:0]                    gnt_o,
  output logic [N_REQ-1:0]                    rvalid_o,
  output logic [31:0]                         result_o,
  output logic [APU_NUSFLAGS-1:0]             flags_o,
  output logic                                apu_req_o,
  input  logic                                apu_gnt_i,
  output logic [APU_NARGS_CPU*32-1:0]         apu_operands_o,
  output logic [APU_WOP_CPU-1:0]              apu_op_o,
  input  logic                                apu_rvalid_i,
  input  logic [31:0]                         apu_result_i,
  input  logic [APU_NUSFLAGS-1:0]             apu_flags_i,
  output logic [$clog2(DEPTH):0]              outstanding_o,
  output logic                                spurious_o
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int OPND_W = APU_NARGS_CPU * 32;

  // Arbitration state
  logic [ID_W-1:0]  rr_ptr;
  logic             lock;
  logic [ID_W-1:0]  lock_id;

  // Response-routing ID FIFO
  logic [ID_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  head_id;
  logic             full;
  logic             empty;
  logic             handshake;
  logic             pop;

  // Full uses only the registered count, so a pop in the same cycle does not
  // let a new request through.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = fifo_mem[rd_ptr];

  // Winner selection: a locked (offered but not yet granted) request keeps
  // the port; otherwise search upward from rr_ptr, wrapping at N_REQ.
  // NOTE: every signal driven in always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin : win_sel
    logic found;
    int   idx;
    winner = lock_id;
    found  = 1'b0;
    idx    = 0;
    if (!lock) begin
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
        idx = (int'(rr_ptr) + i) % N_REQ;
        if (!found && req_i[idx]) begin
          winner = ID_W'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign apu_req_o      = ~full & (lock | (|req_i));
  assign handshake      = apu_req_o & apu_gnt_i;
  assign pop            = apu_rvalid_i & ~empty;
  assign apu_operands_o = apu_req_o ? operands_i[int'(winner)*OPND_W +: OPND_W] : '0;
  assign apu_op_o       = apu_req_o ? op_i[int'(winner)*APU_WOP_CPU +: APU_WOP_CPU] : '0;

  // Response data is broadcast unqualified; requesters qualify with rvalid_o.
  assign result_o      = apu_result_i;
  assign flags_o       = apu_flags_i;
  assign outstanding_o = count;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    if (handshake) gnt_o[winner]   = 1'b1;
    if (pop)       rvalid_o[head_id] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_id    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      spurious_o <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        lock   <= 1'b0;
        wr_ptr <= wr_ptr + 1'b1;
      end else if (apu_req_o) begin
        // Offered but not accepted: pin this requester until it is granted.
        lock    <= 1'b1;
        lock_id <= winner;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({handshake, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (apu_rvalid_i && empty) spurious_o <= 1'b1;
    end
  end

  // NOTE: the ID storage has no reset; an entry is only read after it has
  // been written, and the pointers/count that guard it are reset.
  always_ff @(posedge clk) begin
    if (handshake) fifo_mem[wr_ptr] <= winner;
  end

endmodule
